// File: rtl/picorv32_mem_axi_bridge_if.sv
// Bus bundle for the PicoRV32-to-AXI4-lite bridge.
// Carries the CPU native memory port (mem_*) and the five AXI4-lite
// channels (mem_axi_*).
//   master : bridge view (accepts CPU requests, drives AXI valids/payloads)
//   slave  : environment view (CPU requester plus AXI memory slave)
interface picorv32_mem_axi_bridge_if;
    // CPU native port
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    // AXI4-lite write address / data / response
    logic        mem_axi_awvalid;
    logic        mem_axi_awready;
    logic [31:0] mem_axi_awaddr;
    logic [2:0]  mem_axi_awprot;
    logic        mem_axi_wvalid;
    logic        mem_axi_wready;
    logic [31:0] mem_axi_wdata;
    logic [3:0]  mem_axi_wstrb;
    logic        mem_axi_bvalid;
    logic        mem_axi_bready;

    // AXI4-lite read address / data
    logic        mem_axi_arvalid;
    logic        mem_axi_arready;
    logic [31:0] mem_axi_araddr;
    logic [2:0]  mem_axi_arprot;
    logic        mem_axi_rvalid;
    logic        mem_axi_rready;
    logic [31:0] mem_axi_rdata;

    modport master (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
        input  mem_axi_awready,
        output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
        input  mem_axi_wready,
        input  mem_axi_bvalid,
        output mem_axi_bready,
        output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
        input  mem_axi_arready,
        input  mem_axi_rvalid, mem_axi_rdata,
        output mem_axi_rready
    );

    modport slave (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
        output mem_axi_awready,
        input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
        output mem_axi_wready,
        output mem_axi_bvalid,
        input  mem_axi_bready,
        input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
        output mem_axi_arready,
        output mem_axi_rvalid, mem_axi_rdata,
        input  mem_axi_rready
    );
endinterface

// File: rtl/picorv32_mem_axi_bridge.sv
// PicoRV32 native memory port to AXI4-lite master bridge.
// One access at a time; request fields are latched on accept and every
// CPU-side and AXI-side output comes straight from a flop.
// Ports:
//   clk         : clock, rising edge
//   resetn      : synchronous active-low reset
//   bus         : picorv32_mem_axi_bridge_if.master (CPU port + AXI channels)
//   timeout_err : sticky watchdog flag (only when BRIDGE_TIMEOUT_EN is defined)
// Optional feature macro: BRIDGE_TIMEOUT_EN enables a per-transaction
// watchdog counter that sets timeout_err after TIMEOUT_CYCLES waiting
// cycles; the transaction itself is never aborted.
module picorv32_mem_axi_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          resetn,
    picorv32_mem_axi_bridge_if.master     bus
`ifdef BRIDGE_TIMEOUT_EN
    ,
    output logic                          timeout_err
`endif
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        WADDR_DATA,
        WRESP,
        RADDR,
        RDATA,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [2:0]          arprot_q, arprot_d;

    // Handshake strobes for the current cycle
    logic aw_fire_c, w_fire_c, b_fire_c, ar_fire_c, r_fire_c;
    // A write channel is finished if it already handshook or does so now
    logic aw_done_c, w_done_c;

    assign aw_fire_c = awvalid_q && bus.mem_axi_awready;
    assign w_fire_c  = wvalid_q  && bus.mem_axi_wready;
    assign b_fire_c  = bready_q  && bus.mem_axi_bvalid;
    assign ar_fire_c = arvalid_q && bus.mem_axi_arready;
    assign r_fire_c  = rready_q  && bus.mem_axi_rvalid;
    assign aw_done_c = !awvalid_q || bus.mem_axi_awready;
    assign w_done_c  = !wvalid_q  || bus.mem_axi_wready;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        mem_ready_d = 1'b0;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        arprot_d    = arprot_q;

        case (state_q)
            IDLE: begin
                if (bus.mem_valid) begin
                    addr_d = bus.mem_addr;
                    if (bus.mem_wstrb != '0) begin
                        wdata_d   = bus.mem_wdata;
                        wstrb_d   = bus.mem_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WADDR_DATA;
                    end else begin
                        arprot_d  = {bus.mem_instr, 2'b00};
                        arvalid_d = 1'b1;
                        state_d   = RADDR;
                    end
                end
            end
            WADDR_DATA: begin
                if (aw_fire_c) awvalid_d = 1'b0;
                if (w_fire_c)  wvalid_d  = 1'b0;
                if (aw_done_c && w_done_c) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (b_fire_c) begin
                    bready_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    state_d     = DONE;
                end
            end
            RADDR: begin
                if (ar_fire_c) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (r_fire_c) begin
                    rready_d    = 1'b0;
                    rdata_d     = bus.mem_axi_rdata;
                    mem_ready_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // mem_valid is still high here for the finished request
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            mem_ready_q <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            arprot_q    <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            mem_ready_q <= mem_ready_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            arprot_q    <= arprot_d;
        end
    end

    assign bus.mem_ready       = mem_ready_q;
    assign bus.mem_rdata       = rdata_q;
    assign bus.mem_axi_awvalid = awvalid_q;
    assign bus.mem_axi_awaddr  = addr_q;
    assign bus.mem_axi_awprot  = 3'b000;
    assign bus.mem_axi_wvalid  = wvalid_q;
    assign bus.mem_axi_wdata   = wdata_q;
    assign bus.mem_axi_wstrb   = wstrb_q;
    assign bus.mem_axi_bready  = bready_q;
    assign bus.mem_axi_arvalid = arvalid_q;
    assign bus.mem_axi_araddr  = addr_q;
    assign bus.mem_axi_arprot  = arprot_q;
    assign bus.mem_axi_rready  = rready_q;

`ifdef BRIDGE_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;
    logic        waiting_c;

    assign waiting_c = (state_q == WADDR_DATA) || (state_q == WRESP) ||
                       (state_q == RADDR)      || (state_q == RDATA);

    // Watchdog: restart on accept, count waiting cycles, saturate at all-ones
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if ((state_q == IDLE) && (state_d != IDLE)) begin
            wd_cnt_d = '0;
        end else if (waiting_c && (wd_cnt_q != '1)) begin
            wd_cnt_d = wd_cnt_q + 32'd1;
        end
        if (waiting_c && (wd_cnt_d >= TIMEOUT_LIMIT)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`endif

endmodule

// File: tb/tb_picorv32_mem_axi_bridge.sv
// Self-checking bench for picorv32_mem_axi_bridge.
// A delay-programmable AXI4-lite memory slave answers the bridge; a separate
// reference memory is updated from the CPU's point of view and read results,
// latencies (3 + stalls) and AXI payloads are compared against it.
module tb_picorv32_mem_axi_bridge;

    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    picorv32_mem_axi_bridge_if bus();

`ifdef BRIDGE_TIMEOUT_EN
    logic timeout_err;
`endif

    picorv32_mem_axi_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus)
`ifdef BRIDGE_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    int total = 0;
    int bad = 0;

    // slave stall knobs (cycles the slave waits before answering)
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

    // monitor captures
    logic        aw_got = 0, w_got = 0, ar_got = 0;
    logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
    logic [3:0]  cap_wstrb = 0;
    logic [2:0]  cap_awprot = 0, cap_arprot = 0;
    int          ar_n = 0, aw_n = 0;

    logic [31:0] slave_mem [16];
    logic [31:0] ref_mem [16];

    // per-cycle traces of the last CPU request (index = cycles after accept edge)
    logic [63:0] tr_aw, tr_w, tr_b, tr_ar, tr_r;
    logic        stable_ok;

    function automatic logic [31:0] init_word(input int i);
        init_word = (i == 0) ? 32'hCAFE_BABE : (32'h5A00_0000 + 32'(i) * 32'h0001_0203);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // AXI slave responses, driven on the falling edge
    always @(negedge clk) begin
        if (!resetn) begin
            bus.mem_axi_awready = 1'b0; bus.mem_axi_wready = 1'b0;
            bus.mem_axi_bvalid  = 1'b0; bus.mem_axi_arready = 1'b0;
            bus.mem_axi_rvalid  = 1'b0; bus.mem_axi_rdata = 32'h0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (bus.mem_axi_awvalid) begin
                bus.mem_axi_awready = (aw_cnt == aw_dly); aw_cnt++;
            end else begin
                bus.mem_axi_awready = 1'b0; aw_cnt = 0;
            end
            if (bus.mem_axi_wvalid) begin
                bus.mem_axi_wready = (w_cnt == w_dly); w_cnt++;
            end else begin
                bus.mem_axi_wready = 1'b0; w_cnt = 0;
            end
            if (bus.mem_axi_bready && aw_got && w_got) begin
                bus.mem_axi_bvalid = (b_cnt == b_dly); b_cnt++;
            end else begin
                bus.mem_axi_bvalid = 1'b0; b_cnt = 0;
            end
            if (bus.mem_axi_arvalid) begin
                bus.mem_axi_arready = (ar_cnt == ar_dly); ar_cnt++;
            end else begin
                bus.mem_axi_arready = 1'b0; ar_cnt = 0;
            end
            if (bus.mem_axi_rready && ar_got) begin
                bus.mem_axi_rvalid = (r_cnt == r_dly); r_cnt++;
            end else begin
                bus.mem_axi_rvalid = 1'b0; r_cnt = 0;
            end
            bus.mem_axi_rdata = bus.mem_axi_rvalid ? slave_mem[cap_araddr[5:2]] : 32'hDEAD_0000;
        end
    end

    // Handshake monitor and slave memory update, on the rising edge
    always @(posedge clk) begin
        if (!resetn) begin
            aw_got = 0; w_got = 0; ar_got = 0;
        end else begin
            if (bus.mem_axi_awvalid && bus.mem_axi_awready) begin
                aw_got = 1; cap_awaddr = bus.mem_axi_awaddr; cap_awprot = bus.mem_axi_awprot; aw_n++;
            end
            if (bus.mem_axi_wvalid && bus.mem_axi_wready) begin
                w_got = 1; cap_wdata = bus.mem_axi_wdata; cap_wstrb = bus.mem_axi_wstrb;
            end
            if (bus.mem_axi_bvalid && bus.mem_axi_bready) begin
                for (int b = 0; b < 4; b++)
                    if (cap_wstrb[b]) slave_mem[cap_awaddr[5:2]][8*b +: 8] = cap_wdata[8*b +: 8];
                aw_got = 0; w_got = 0;
            end
            if (bus.mem_axi_arvalid && bus.mem_axi_arready) begin
                ar_got = 1; cap_araddr = bus.mem_axi_araddr; cap_arprot = bus.mem_axi_arprot; ar_n++;
            end
            if (bus.mem_axi_rvalid && bus.mem_axi_rready) ar_got = 0;
        end
    end

    // One CPU access; lat = edges from accept edge (inclusive) to mem_ready seen
    task automatic cpu_req(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic instr, input bit hold,
                           output logic [31:0] rdata, output int lat);
        bit seen = 0;
        @(negedge clk);
        bus.mem_valid = 1'b1; bus.mem_instr = instr; bus.mem_addr = addr;
        bus.mem_wdata = wdata; bus.mem_wstrb = wstrb;
        tr_aw = 0; tr_w = 0; tr_b = 0; tr_ar = 0; tr_r = 0;
        stable_ok = 1'b1; lat = 0; rdata = 32'h0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            lat++;
            if (lat < 64) begin
                tr_aw[lat] = bus.mem_axi_awvalid; tr_w[lat] = bus.mem_axi_wvalid;
                tr_b[lat] = bus.mem_axi_bready; tr_ar[lat] = bus.mem_axi_arvalid;
                tr_r[lat] = bus.mem_axi_rready;
            end
            if (bus.mem_axi_arvalid && (bus.mem_axi_araddr !== addr || bus.mem_axi_arprot !== {instr, 2'b00}))
                stable_ok = 1'b0;
            if (bus.mem_axi_awvalid && (bus.mem_axi_awaddr !== addr || bus.mem_axi_awprot !== 3'b000))
                stable_ok = 1'b0;
            if (bus.mem_axi_wvalid && (bus.mem_axi_wdata !== wdata || bus.mem_axi_wstrb !== wstrb))
                stable_ok = 1'b0;
            // CPU-side fields change after accept; the bridge must use its latched copy
            if (!hold && lat == 1) begin
                bus.mem_addr = ~addr; bus.mem_wdata = ~wdata;
            end
            if (bus.mem_ready) begin
                rdata = bus.mem_rdata; seen = 1; break;
            end
        end
        if (!seen) lat = -1;
        chk("payload_stable", 64'(stable_ok), 64'd1);
        @(negedge clk);
        if (!hold) bus.mem_valid = 1'b0;
    endtask

    // After completion: no further ready pulse and no new AXI request
    task automatic quiet(input string tag);
        int n = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.mem_ready || bus.mem_axi_arvalid || bus.mem_axi_awvalid || bus.mem_axi_wvalid) n++;
        end
        chk(tag, 64'(n), 64'd0);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({bus.mem_axi_awvalid, bus.mem_axi_wvalid, bus.mem_axi_bready,
                               bus.mem_axi_arvalid, bus.mem_axi_rready, bus.mem_ready}), 64'd0);
        chk({tag, "_addr"}, 64'({bus.mem_axi_awaddr, bus.mem_axi_araddr}), 64'd0);
        chk({tag, "_wd"}, 64'({bus.mem_axi_wdata, bus.mem_axi_wstrb, bus.mem_axi_arprot, bus.mem_axi_awprot}), 64'd0);
        chk({tag, "_rdata"}, 64'(bus.mem_rdata), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] rd, rd2, addr, wd, last_rd;
        logic [3:0]  ws;
        logic        ins;
        int          lat, idx, mx, n0;
        bit          wr;

        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = init_word(i);
            slave_mem[i] = init_word(i);
        end
        bus.mem_valid = 0; bus.mem_instr = 0; bus.mem_addr = 0;
        bus.mem_wdata = 0; bus.mem_wstrb = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        all_zero("reset");
`ifdef BRIDGE_TIMEOUT_EN
        chk("reset_timeout_err", 64'(timeout_err), 64'd0);
`endif
        @(negedge clk); resetn = 1'b1;

        // zero-wait instruction read
        cpu_req(32'h0000_0100, 32'h0, 4'h0, 1'b1, 0, rd, lat);
        chk("rd0_lat", 64'(lat), 64'd3);
        chk("rd0_data", 64'(rd), 64'hCAFE_BABE);
        chk("rd0_araddr", 64'(cap_araddr), 64'h100);
        chk("rd0_arprot", 64'(cap_arprot), 64'b100);
        quiet("rd0_single_pulse");
        last_rd = rd;

        // write: W accepted first, AW three cycles later, B one cycle after bready
        aw_dly = 3; w_dly = 0; b_dly = 1;
        n0 = aw_n;
        cpu_req(32'h1000_0000, 32'h0000_0041, 4'b0001, 1'b0, 0, rd, lat);
        chk("wr_lat", 64'(lat), 64'd7);
        chk("wr_wvalid_c1", 64'(tr_w[1]), 64'd1);
        chk("wr_wvalid_c2", 64'(tr_w[2]), 64'd0);
        chk("wr_awvalid_c4", 64'(tr_aw[4]), 64'd1);
        chk("wr_awvalid_c5", 64'(tr_aw[5]), 64'd0);
        chk("wr_bready_c4_7", 64'({tr_b[4], tr_b[5], tr_b[6], tr_b[7]}), 64'b0110);
        chk("wr_awaddr", 64'(cap_awaddr), 64'h1000_0000);
        chk("wr_wdata_wstrb", 64'({cap_wdata, cap_wstrb}), 64'({32'h41, 4'b0001}));
        chk("wr_rdata_kept", 64'(rd), 64'(last_rd));
        ref_mem[0][7:0] = 8'h41;
        quiet("wr_no_reissue");
        chk("wr_aw_count", 64'(aw_n - n0), 64'd1);

        // stalled read
        aw_dly = 0; b_dly = 0; ar_dly = 5; r_dly = 3;
        cpu_req(32'h2000_0014, 32'h0, 4'h0, 1'b0, 0, rd, lat);
        chk("srd_lat", 64'(lat), 64'd11);
        chk("srd_arvalid_c6_7", 64'({tr_ar[6], tr_ar[7]}), 64'b10);
        chk("srd_rready_c6_7_10_11", 64'({tr_r[6], tr_r[7], tr_r[10], tr_r[11]}), 64'b0110);
        chk("srd_data", 64'(rd), 64'(ref_mem[5]));
        quiet("srd_single_pulse");

        // back-to-back: mem_valid held through DONE, then a new read
        ar_dly = 0; r_dly = 0;
        n0 = ar_n;
        cpu_req(32'h2000_000C, 32'h0, 4'h0, 1'b0, 1, rd, lat);
        cpu_req(32'h2000_0010, 32'h0, 4'h0, 1'b1, 0, rd2, lat);
        chk("b2b_data0", 64'(rd), 64'(ref_mem[3]));
        chk("b2b_data1", 64'(rd2), 64'(ref_mem[4]));
        chk("b2b_lat1", 64'(lat), 64'd3);
        chk("b2b_ar_count", 64'(ar_n - n0), 64'd2);
        chk("b2b_araddr", 64'(cap_araddr), 64'h2000_0010);

        // reset while waiting for the write response
        b_dly = 30;
        @(negedge clk);
        bus.mem_valid = 1'b1; bus.mem_addr = 32'h2000_0008; bus.mem_wdata = 32'h1234_5678;
        bus.mem_wstrb = 4'hF; bus.mem_instr = 1'b0;
        begin
            bit in_wresp = 0;
            for (int k = 0; k < 20 && !in_wresp; k++) begin
                @(posedge clk); #1;
                in_wresp = bus.mem_axi_bready;
            end
            chk("rst_reach_wresp", 64'(in_wresp), 64'd1);
        end
        @(negedge clk); resetn = 1'b0; bus.mem_valid = 1'b0; bus.mem_wstrb = 4'h0;
        @(posedge clk); #1;
        all_zero("midrst");
        @(posedge clk);
        @(negedge clk); resetn = 1'b1; b_dly = 0;
        cpu_req(32'h2000_0008, 32'h0, 4'h0, 1'b0, 0, rd, lat);
        chk("midrst_read_data", 64'(rd), 64'(ref_mem[2]));
        chk("midrst_read_lat", 64'(lat), 64'd3);
        last_rd = rd;

        // randomized mix against the reference memory
        for (int t = 0; t < 30; t++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            idx  = $urandom_range(0, 7);
            addr = 32'h2000_0000 + 32'(idx) * 32'd4;
            wr   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            ws   = wr ? 4'($urandom_range(1, 15)) : 4'h0;
            ins  = wr ? 1'b0 : 1'($urandom_range(0, 1));
            cpu_req(addr, wd, ws, ins, 0, rd, lat);
            if (wr) begin
                mx = (aw_dly > w_dly) ? aw_dly : w_dly;
                chk("rnd_wr_lat", 64'(lat), 64'(3 + mx + b_dly));
                chk("rnd_wr_aw", 64'({cap_awaddr, cap_awprot}), 64'({addr, 3'b000}));
                chk("rnd_wr_w", 64'({cap_wdata, cap_wstrb}), 64'({wd, ws}));
                chk("rnd_wr_rdata_kept", 64'(rd), 64'(last_rd));
                for (int b = 0; b < 4; b++)
                    if (ws[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                chk("rnd_rd_lat", 64'(lat), 64'(3 + ar_dly + r_dly));
                chk("rnd_rd_ar", 64'({cap_araddr, cap_arprot}), 64'({addr, ins, 2'b00}));
                chk("rnd_rd_data", 64'(rd), 64'(ref_mem[idx]));
                last_rd = rd;
            end
        end

`ifdef BRIDGE_TIMEOUT_EN
        // watchdog: AR never accepted
        ar_dly = 1_000_000;
        @(negedge clk);
        bus.mem_valid = 1'b1; bus.mem_addr = 32'h2000_0018; bus.mem_wstrb = 4'h0; bus.mem_instr = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 8)  chk("tmo_not_yet", 64'(timeout_err), 64'd0);
            if (k == 9)  chk("tmo_set", 64'(timeout_err), 64'd1);
            if (k == 12) chk("tmo_sticky_arvalid", 64'({timeout_err, bus.mem_axi_arvalid}), 64'b11);
        end
        @(negedge clk); resetn = 1'b0; bus.mem_valid = 1'b0;
        @(posedge clk); #1;
        chk("tmo_cleared", 64'(timeout_err), 64'd0);
        @(posedge clk);
        @(negedge clk); resetn = 1'b1; ar_dly = 0;
        cpu_req(32'h2000_0018, 32'h0, 4'h0, 1'b0, 0, rd, lat);
        chk("tmo_after_read", 64'(rd), 64'(ref_mem[6]));
        chk("tmo_after_flag", 64'(timeout_err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
